freq_gen: RTL and testbench



---
 rtl/freq_gen.sv | 140 ++++++++++++++
 tb/tb_freq_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gen.sv
// Programmable square-wave generator: a serial restoring divider turns a
// requested frequency into a half-period count that drives a toggle counter.
module freq_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned QW     = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   freq,
  input  logic          load,
  input  logic          en,
  output logic          signal,
  output logic          busy,
  output logic [QW-1:0] half_period
);

  localparam int unsigned    BW       = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [QW-1:0]  DIVIDEND = QW'(CLK_HZ);
  localparam logic [QW-1:0]  ONE      = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]  TOP_BIT  = BW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [16:0]     divisor_q, divisor_d;
  logic [16:0]     rem_q, rem_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [QW-1:0]   hp_q, hp_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic            sig_q, sig_d;

  logic [17:0]     rem_shift;
  logic [16:0]     rem_sub;
  logic            q_bit;
  logic [QW-1:0]   quot_next;
  logic            load_ok;
  logic            toggle_on;

  // A zero quotient means the request exceeds CLK_HZ/2; run as fast as possible.
  function automatic logic [QW-1:0] clamp_hp(input logic [QW-1:0] q);
    return (q == '0) ? ONE : q;
  endfunction

  // One restoring-division step: bring down the next dividend bit, MSB first.
  assign rem_shift = {rem_q, DIVIDEND[bit_q]};
  assign q_bit     = (rem_shift >= {1'b0, divisor_q});
  assign rem_sub   = rem_shift[16:0] - divisor_q;
  assign quot_next = {quot_q[QW-2:0], q_bit};

  assign load_ok   = load && (state_q != DIV);
  assign toggle_on = en && (hp_q != '0) && (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    bit_d     = bit_q;
    hp_d      = hp_q;
    cnt_d     = '0;
    sig_d     = 1'b0;

    // The old waveform keeps running while a new division is in flight.
    if (toggle_on) begin
      if (cnt_q == hp_q - ONE) begin
        cnt_d = '0;
        sig_d = ~sig_q;
      end else begin
        cnt_d = cnt_q + ONE;
        sig_d = sig_q;
      end
    end

    case (state_q)
      IDLE, RUN: begin
        if (load_ok) begin
          if (freq == 16'd0) begin
            state_d = IDLE;
            hp_d    = '0;
            cnt_d   = '0;
            sig_d   = 1'b0;
          end else begin
            state_d   = DIV;
            divisor_d = {freq, 1'b0};
            rem_d     = '0;
            quot_d    = '0;
            bit_d     = TOP_BIT;
          end
        end
      end
      DIV: begin
        rem_d  = q_bit ? rem_sub : rem_shift[16:0];
        quot_d = quot_next;
        bit_d  = bit_q - 1'b1;
        if (bit_q == '0) begin
          state_d = RUN;
          hp_d    = clamp_hp(quot_next);
          cnt_d   = '0;
          sig_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        hp_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      bit_q     <= '0;
      hp_q      <= '0;
      cnt_q     <= '0;
      sig_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      bit_q     <= bit_d;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      sig_q     <= sig_d;
    end
  end

  assign signal      = sig_q;
  assign busy        = (state_q == DIV);
  assign half_period = hp_q;

endmodule

// File: tb/tb_freq_gen.sv
// Scoreboard bench for freq_gen: a 50 MHz instance for the main sequences and
// a 100 Hz instance for the clamped-quotient case.
module tb_freq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] freq_a, freq_b;
  logic        load_a, load_b, en_a, en_b;
  logic        sig_a, busy_a, sig_b, busy_b;
  logic [26:0] hp_a;
  logic [6:0]  hp_b;

  freq_gen #(.CLK_HZ(50_000_000), .QW(27)) dut_a (
    .clk(clk), .rst(rst), .freq(freq_a), .load(load_a), .en(en_a),
    .signal(sig_a), .busy(busy_a), .half_period(hp_a)
  );

  freq_gen #(.CLK_HZ(100), .QW(7)) dut_b (
    .clk(clk), .rst(rst), .freq(freq_b), .load(load_b), .en(en_b),
    .signal(sig_b), .busy(busy_b), .half_period(hp_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [26:0] hp;
    int          bcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   rst_pulses  = 0;
  int   seen_pulses = 0;
  int   bcnt        = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pops one expectation per completed division on dut_a.
  always @(negedge clk) begin
    if (rst || seen_pulses != rst_pulses) begin
      bcnt        = 0;
      seen_pulses = rst_pulses;
    end else if (busy_a) begin
      bcnt++;
    end else if (bcnt != 0) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_div", bcnt, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sb_busy_cycles", bcnt, mon_e.bcyc);
        check_val("sb_half_period", hp_a, mon_e.hp);
        check_val("sb_phase_restart", sig_a, 0);
      end
      bcnt = 0;
    end
  end

  task automatic load_a_f(input logic [15:0] f);
    freq_a = f;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (busy_a && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, busy_a, 0);
  endtask

  task automatic time_to(input logic v, input int maxc, output int n);
    n = 0;
    while (sig_a !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; load_a = 1'b0; load_b = 1'b0;
    freq_a = '0; freq_b = '0; en_a = 1'b1; en_b = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_signal", sig_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_hp", hp_a, 0);
    check_val("rst_hp_b", hp_b, 0);
    rst = 1'b0;

    // First edge after reset with load=1 is accepted.
    exp_q.push_back('{27'd25000, 27});
    load_a_f(16'd1000);
    check_val("busy_after_load", busy_a, 1);
    check_val("hp_old_during_div", hp_a, 0);
    wait_not_busy("div_1000_done");
    time_to(1'b1, 30000, n);
    check_val("t_rise_1000", n, 25000);
    time_to(1'b0, 30000, n);
    check_val("t_high_1000", n, 25000);

    exp_q.push_back('{27'd381, 27});
    load_a_f(16'd65535);
    wait_not_busy("div_65535_done");
    time_to(1'b1, 1000, n);
    check_val("t_rise_65535", n, 381);
    time_to(1'b0, 1000, n);
    check_val("t_high_65535", n, 381);

    en_a = 1'b0;
    @(negedge clk);
    check_val("en_low_sig", sig_a, 0);
    repeat (5) @(negedge clk);
    check_val("en_low_hold", sig_a, 0);
    en_a = 1'b1;
    time_to(1'b1, 1000, n);
    check_val("en_resume_first_toggle", n, 381);

    load_a_f(16'd0);
    check_val("stop_hp", hp_a, 0);
    check_val("stop_sig", sig_a, 0);
    check_val("stop_busy", busy_a, 0);
    for (int i = 0; i < 4; i++) begin
      en_a = ~en_a;
      @(negedge clk);
      check_val("idle_en_sig", sig_a, 0);
      check_val("idle_en_busy", busy_a, 0);
    end
    en_a = 1'b1;

    exp_q.push_back('{27'd25000, 27});
    load_a_f(16'd1000);
    wait_not_busy("div_1000b_done");
    repeat (10) @(negedge clk);
    check_val("hp_before_reload", hp_a, 25000);
    exp_q.push_back('{27'd12500, 27});
    load_a_f(16'd2000);
    @(negedge clk);
    freq_a = 16'd5;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    check_val("busy_during_ignored", busy_a, 1);
    check_val("hp_kept_during_div", hp_a, 25000);
    wait_not_busy("div_2000_done");
    check_val("hp_2000", hp_a, 12500);

    // Abort a division with an asynchronous reset pulse between edges.
    load_a_f(16'd1000);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    rst_pulses++;
    #1;
    check_val("async_rst_sig", sig_a, 0);
    check_val("async_rst_busy", busy_a, 0);
    check_val("async_rst_hp", hp_a, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_abort_busy", busy_a, 0);
    check_val("post_abort_hp", hp_a, 0);
    exp_q.push_back('{27'd25000, 27});
    load_a_f(16'd1000);
    wait_not_busy("div_after_rst_done");
    check_val("hp_after_rst", hp_a, 25000);

    // Quotient of zero clamps to a one-cycle half period.
    freq_b = 16'd60;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    n = 0;
    while (busy_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("b_busy_cycles", n, 7);
    check_val("b_hp_clamped", hp_b, 1);
    check_val("b_sig_restart", sig_b, 0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_val("b_toggle_every_cycle", sig_b, i % 2);
    end
    freq_b = 16'd20;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    n = 0;
    while (busy_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("b_hp_20", hp_b, 2);

    check_val("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
